// File: rtl/hs_ifr_arb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
//======================================================================
// Module : hs_ifr_arb_pkg
// Brief  : Shared types for the word-channel arbiters.
// Rev    : 1.0
//======================================================================
package hs_ifr_arb_pkg;

    typedef hs_ifr_int_typedefs_pkg::lg_word_t lg_word_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/hs_ifr_int_typedefs_pkg.sv
`default_nettype none
`timescale 1ns/1ps
//======================================================================
// Module : hs_ifr_int_typedefs_pkg
// Brief  : Interconnect-wide scalar word types.
// Rev    : 1.0
//======================================================================
package hs_ifr_int_typedefs_pkg;

    typedef logic [31:0] lg_word_t;

endpackage
`default_nettype wire

// File: rtl/hs_ifr_rr_pick.sv
`default_nettype none
`timescale 1ns/1ps
//======================================================================
// Module : hs_ifr_rr_pick
// Brief  : Combinational round-robin pick: first set request at or above ptr, with wrap.
// Rev    : 1.0
//======================================================================
module hs_ifr_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    localparam logic [ID_W:0] N_EXT = (ID_W + 1)'(NUM_REQ);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] pos;
    logic            found;

    // Walking the rotated order ptr, ptr+1, ... and stopping at the first hit
    // is the rotate / priority-encode / rotate-back in one pass.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(i);
            if (sum >= N_EXT) begin
                sum = sum - N_EXT;
            end
            pos = sum[ID_W-1:0];
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
        grant[idx] = found;
    end

endmodule
`default_nettype wire

// File: rtl/hs_ifr_word_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//======================================================================
// Module : hs_ifr_word_rr_arbiter
// Brief  : Packet-level round-robin arbiter sharing one 32-bit valid/ready word channel.
// Rev    : 1.0
//======================================================================
module hs_ifr_word_rr_arbiter
    import hs_ifr_arb_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int IDLE_TIMEOUT = 15,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ-1:0]       req_last_i,
    input  lg_word_t [NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     tgt_valid_o,
    output logic                     tgt_last_o,
    output lg_word_t                 tgt_data_o,
    output logic [ID_W-1:0]          tgt_id_o,
    input  logic                     tgt_ready_i,
    output logic                     timeout_o
);

    localparam int               CNT_W     = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam int               TO_LAST_I = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_LAST_I);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

    arb_state_e         state_q;
    logic [ID_W-1:0]    own_q;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   idle_cnt;
    logic [ID_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    ptr_after_own;
    logic               busy;
    logic               own_valid;
    logic               own_last;
    lg_word_t           own_data;
    logic               to_fire;

    hs_ifr_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req_valid_i),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign busy          = (state_q == BUSY);
    assign own_valid     = req_valid_i[own_q];
    assign own_last      = req_last_i[own_q];
    assign own_data      = req_data_i[own_q];
    assign ptr_after_own = (own_q == LAST_ID) ? '0 : own_q + ID_W'(1);

    // Fires in the cycle the counter would reach IDLE_TIMEOUT, so release
    // and the pulse coincide with the last silent owner cycle.
    assign to_fire = busy && !own_valid && (IDLE_TIMEOUT != 0) && (idle_cnt == TO_LAST);

    always_comb begin
        req_ready_o = '0;
        tgt_valid_o = 1'b0;
        tgt_last_o  = 1'b0;
        tgt_data_o  = '0;
        if (busy) begin
            req_ready_o[own_q] = tgt_ready_i;
            tgt_valid_o        = own_valid;
            tgt_last_o         = own_last;
            tgt_data_o         = own_data;
        end
    end

    assign tgt_id_o  = own_q;
    assign timeout_o = to_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            own_q    <= '0;
            rr_ptr   <= '0;
            idle_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pick_grant) begin
                        own_q    <= pick_idx;
                        idle_cnt <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (own_valid) begin
                        idle_cnt <= '0;
                        if (tgt_ready_i && own_last) begin
                            state_q <= IDLE;
                            rr_ptr  <= ptr_after_own;
                        end
                    end else begin
                        if (idle_cnt != '1) begin
                            idle_cnt <= idle_cnt + CNT_W'(1);
                        end
                        if (to_fire) begin
                            state_q <= IDLE;
                            rr_ptr  <= ptr_after_own;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hs_ifr_word_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//======================================================================
// Module : tb_hs_ifr_word_rr_arbiter
// Brief  : Directed scoreboard bench for hs_ifr_word_rr_arbiter (4 requesters, timeout 3).
// Rev    : 1.0
//======================================================================
module tb_hs_ifr_word_rr_arbiter;
    import hs_ifr_arb_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic [1:0] id;
        lg_word_t   data;
        logic       last;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req_valid_i;
    logic [N-1:0]       req_last_i;
    lg_word_t [N-1:0]   req_data_i;
    logic [N-1:0]       req_ready_o;
    logic               tgt_valid_o;
    logic               tgt_last_o;
    lg_word_t           tgt_data_o;
    logic [1:0]         tgt_id_o;
    logic               tgt_ready_i;
    logic               timeout_o;

    exp_t        exp_q[$];
    logic [32:0] src_q[N][$];
    int          xfer_cyc[$];
    int          to_cyc[$];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hs_ifr_word_rr_arbiter #(
        .NUM_REQ      (N),
        .IDLE_TIMEOUT (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .tgt_valid_o (tgt_valid_o),
        .tgt_last_o  (tgt_last_o),
        .tgt_data_o  (tgt_data_o),
        .tgt_id_o    (tgt_id_o),
        .tgt_ready_i (tgt_ready_i),
        .timeout_o   (timeout_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic beat(input int r, input int data, input logic last);
        exp_t e;
        src_q[r].push_back({last, 32'(data)});
        e.id   = 2'(r);
        e.data = 32'(data);
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic pkt(input int r, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            beat(r, base + i, (i == n - 1));
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int r = 0; r < N; r++) s += src_q[r].size();
        return s;
    endfunction

    task automatic wait_xfers(input int n, input int budget);
        int k = 0;
        while (xfer_cyc.size() < n && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        chk("wait_xfers", 64'(xfer_cyc.size() >= n), 64'(1));
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || pending() != 0) && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        chk("drain", 64'(exp_q.size() + pending()), 64'(0));
        exp_q.delete();
        for (int r = 0; r < N; r++) src_q[r].delete();
        repeat (3) @(posedge clk);
        #2;
    endtask

    // Requester sources: present queue head, pop on a sampled handshake.
    initial begin
        logic [N-1:0] hs;
        logic [32:0]  b;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        forever begin
            @(negedge clk);
            hs = req_valid_i & req_ready_o;
            @(posedge clk); #1;
            for (int r = 0; r < N; r++) begin
                if (hs[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
                b = (src_q[r].size() > 0) ? src_q[r][0] : 33'd0;
                req_valid_i[r] = (src_q[r].size() > 0);
                req_last_i[r]  = b[32];
                req_data_i[r]  = b[31:0];
            end
        end
    end

    // Monitor: compare every presented beat against the scoreboard head.
    initial begin
        exp_t         e;
        logic [N-1:0] one;
        logic [N-1:0] rdy;
        one = 4'b0001;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (timeout_o) to_cyc.push_back(cyc);
                if (tgt_valid_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'({tgt_id_o, tgt_data_o}), 64'(0));
                    end else begin
                        e   = exp_q[0];
                        rdy = tgt_ready_i ? (one << e.id) : '0;
                        chk("beat", 64'({tgt_id_o, tgt_data_o, tgt_last_o}), 64'(e));
                        chk("req_ready", 64'(req_ready_o), 64'(rdy));
                        if (tgt_ready_i) begin
                            void'(exp_q.pop_front());
                            xfer_cyc.push_back(cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pc;
        rst_n       = 1'b0;
        tgt_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outs", 64'({tgt_valid_o, tgt_last_o, tgt_data_o, tgt_id_o, req_ready_o, timeout_o}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("idle_outs", 64'({tgt_valid_o, tgt_last_o, tgt_data_o, tgt_id_o, req_ready_o, timeout_o}), 64'(0));

        // Rotation from reset: 0,1,2,3,0 with a dead cycle between grants
        tgt_ready_i = 1'b1;
        xfer_cyc.delete();
        to_cyc.delete();
        pkt(0, 1, 'h10); pkt(1, 1, 'h11); pkt(2, 1, 'h12); pkt(3, 1, 'h13); pkt(0, 1, 'h14);
        wait_drain(100);
        chk("rot_count", 64'(xfer_cyc.size()), 64'(5));
        if (xfer_cyc.size() == 5) begin
            for (int i = 1; i < 5; i++) chk("rot_gap", 64'(xfer_cyc[i] - xfer_cyc[i-1]), 64'(2));
        end

        // No interleave: ptr moved to 2, then 2 sends 3 beats while 1 waits
        pkt(1, 1, 'h20);
        wait_drain(50);
        xfer_cyc.delete();
        pkt(2, 3, 'hA0); pkt(1, 1, 'hB0);
        wait_drain(100);
        chk("ni_count", 64'(xfer_cyc.size()), 64'(4));
        if (xfer_cyc.size() == 4) begin
            chk("ni_gap01", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'(1));
            chk("ni_gap12", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'(1));
            chk("ni_gap23", 64'(xfer_cyc[3] - xfer_cyc[2]), 64'(2));
        end

        // Backpressure on beat 3 of 4 for 5 cycles
        xfer_cyc.delete();
        pkt(2, 4, 'hC0);
        wait_xfers(2, 50);
        tgt_ready_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        tgt_ready_i = 1'b1;
        wait_drain(100);
        chk("bp_count", 64'(xfer_cyc.size()), 64'(4));
        if (xfer_cyc.size() == 4) chk("bp_stall", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'(6));
        chk("bp_no_timeout", 64'(to_cyc.size()), 64'(0));

        // Timeout: owner 0 goes silent after a non-last beat; 1 is waiting
        pkt(3, 1, 'h30);
        wait_drain(50);
        xfer_cyc.delete();
        to_cyc.delete();
        beat(0, 'hD0, 1'b0);
        pkt(1, 1, 'hD1);
        wait_drain(100);
        chk("to_count", 64'(to_cyc.size()), 64'(1));
        if (to_cyc.size() == 1 && xfer_cyc.size() == 2) begin
            chk("to_when", 64'(to_cyc[0] - xfer_cyc[0]), 64'(3));
            chk("to_next", 64'(xfer_cyc[1] - to_cyc[0]), 64'(2));
        end

        // Asynchronous reset during beat 2 of 4
        xfer_cyc.delete();
        pkt(2, 4, 'hE0);
        wait_xfers(1, 50);
        rst_n = 1'b0;
        #1;
        chk("rst_async", 64'({tgt_valid_o, tgt_last_o, tgt_data_o, tgt_id_o, req_ready_o, timeout_o}), 64'(0));
        exp_q.delete();
        for (int r = 0; r < N; r++) src_q[r].delete();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        pkt(0, 1, 'hF0); pkt(2, 1, 'hF2);
        wait_drain(100);

        // Sparse: ptr is 3, only requester 1 valid; afterwards ptr must be 2
        xfer_cyc.delete();
        pc = cyc;
        pkt(1, 2, 'h60);
        wait_drain(100);
        chk("sparse_count", 64'(xfer_cyc.size()), 64'(2));
        if (xfer_cyc.size() == 2) chk("sparse_latency", 64'(xfer_cyc[0] - pc), 64'(2));
        pkt(2, 1, 'h62); pkt(3, 1, 'h63);
        wait_drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
